// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes SPI command words into RAM accesses and shares the
// single RAM port with a local host port under round-robin arbitration.
module spi_ram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [9:0]            rx_data,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  spi_ovf
);
    typedef enum logic [2:0] {IDLE, SPI_ACC, HOST_ACC, SPI_RD, HOST_RD} state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  rx_prev_q, rx_prev_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, op_addr_q, op_addr_d;
    logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
    logic                  spi_pend_q, spi_pend_d, op_we_q, op_we_d, spi_ovf_q, spi_ovf_d;
    logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  host_gnt_q, host_gnt_d, host_rvalid_q, host_rvalid_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  accept, spi_go, host_go;

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        rx_prev_d     = rx_valid;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        op_addr_d     = op_addr_q;
        op_data_d     = op_data_q;
        op_we_d       = op_we_q;
        spi_pend_d    = spi_pend_q;
        spi_ovf_d     = spi_ovf_q;
        ram_en_d      = 1'b0;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        host_gnt_d    = 1'b0;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        tx_valid_d    = 1'b0;
        tx_data_d     = tx_data_q;
        spi_go        = 1'b0;
        host_go       = 1'b0;
        accept        = rx_valid & ~rx_prev_q;
        // opcode bit 8 clear = address latch, set = data op (bit 9 selects read)
        if (accept) begin
            if (!rx_data[8]) begin
                if (rx_data[9]) rd_addr_d = rx_data[7:0];
                else wr_addr_d = rx_data[7:0];
            end else if (spi_pend_q) begin
                spi_ovf_d = 1'b1;
            end else begin
                spi_pend_d = 1'b1;
                op_we_d    = ~rx_data[9];
                op_addr_d  = rx_data[9] ? rd_addr_q : wr_addr_q;
                op_data_d  = rx_data[9] ? op_data_q : rx_data[7:0];
            end
        end
        case (state_q)
            IDLE: begin
                spi_go  = spi_pend_q & (~host_req | ~prio_q);
                host_go = host_req & ~spi_go;
                if (spi_go) begin
                    state_d     = SPI_ACC;
                    ram_en_d    = 1'b1;
                    ram_we_d    = op_we_q;
                    ram_addr_d  = op_addr_q;
                    ram_wdata_d = op_data_q;
                    spi_pend_d  = 1'b0;
                    prio_d      = 1'b1;
                end else if (host_go) begin
                    state_d     = HOST_ACC;
                    ram_en_d    = 1'b1;
                    ram_we_d    = host_we;
                    ram_addr_d  = host_addr;
                    ram_wdata_d = host_wdata;
                    host_gnt_d  = 1'b1;
                    prio_d      = 1'b0;
                end
            end
            SPI_ACC:  state_d = ram_we_q ? IDLE : SPI_RD;
            HOST_ACC: state_d = ram_we_q ? IDLE : HOST_RD;
            SPI_RD: begin
                tx_data_d  = ram_rdata;
                tx_valid_d = 1'b1;
                state_d    = IDLE;
            end
            HOST_RD: begin
                host_rdata_d  = ram_rdata;
                host_rvalid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            rx_prev_q     <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            op_addr_q     <= '0;
            op_data_q     <= '0;
            op_we_q       <= 1'b0;
            spi_pend_q    <= 1'b0;
            spi_ovf_q     <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            host_gnt_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            rx_prev_q     <= rx_prev_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            op_addr_q     <= op_addr_d;
            op_data_q     <= op_data_d;
            op_we_q       <= op_we_d;
            spi_pend_q    <= spi_pend_d;
            spi_ovf_q     <= spi_ovf_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            host_gnt_q    <= host_gnt_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign host_gnt    = host_gnt_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign spi_ovf     = spi_ovf_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed and randomized checks of spi_ram_ctrl against a
// transaction-level model (command decode, expected RAM contents, pulse timing).
module tb_spi_ram_ctrl;
    logic       clk = 0, rst_n = 1, rx_valid = 0;
    logic [9:0] rx_data = 0;
    logic       tx_valid, host_gnt, host_rvalid, ram_en, ram_we, spi_ovf;
    logic [7:0] tx_data, host_rdata, ram_addr, ram_wdata, ram_rdata;
    logic       host_req = 0, host_we = 0;
    logic [7:0] host_addr = 0, host_wdata = 0;
    logic       fill = 0;
    logic [7:0] fill_a = 0, fill_d = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] m_wr = 0, m_rd = 0;
    int         cyc = 0, n_cmp = 0, n_err = 0, n_tx = 0, n_spi_wr = 0, spi_cyc = 0, host_cyc = 0;

    typedef struct {logic we; logic [7:0] a; logic [7:0] d;} op_t;
    typedef struct {int c; logic [7:0] d;} rd_t;
    op_t sq[$];
    rd_t tq[$];
    rd_t hq[$];

    spi_ram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (fill) mem[fill_a] <= fill_d;
        else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [9:0] w, input int hold, input bit drop);
        rx_data  = w;
        rx_valid = 1;
        if (w[9:8] == 2'b00) m_wr = w[7:0];
        else if (w[9:8] == 2'b10) m_rd = w[7:0];
        else if (!drop) sq.push_back('{we: !w[9], a: (w[9] ? m_rd : m_wr), d: w[7:0]});
        repeat (hold) @(negedge clk);
        rx_valid = 0;
    endtask

    task automatic host_do(input logic we, input logic [7:0] a, input logic [7:0] d);
        bit ok = 0;
        host_we = we; host_addr = a; host_wdata = d; host_req = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = host_gnt;
        end
        host_req = 0;
        if (!ok) chk("host_gnt_timeout", 32'(ok), 1);
    endtask

    task automatic do_reset();
        rst_n = 0; m_wr = 0; m_rd = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic monitor();
        op_t e;
        rd_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sq.delete(); tq.delete(); hq.delete();
            end else begin
                if (host_gnt) begin
                    chk("gnt_strobe", 32'(ram_en), 1);
                    chk("host_addr", 32'(ram_addr), 32'(host_addr));
                    chk("host_we", 32'(ram_we), 32'(host_we));
                    if (host_we) begin
                        chk("host_wdata", 32'(ram_wdata), 32'(host_wdata));
                        ref_mem[host_addr] = host_wdata;
                    end else hq.push_back('{c: cyc, d: ref_mem[host_addr]});
                    host_cyc = cyc;
                end else if (ram_en) begin
                    if (ram_we) n_spi_wr++;
                    if (sq.size() == 0) chk("spi_unexpected", 32'(sq.size()), 1);
                    else begin
                        e = sq.pop_front();
                        chk("spi_we", 32'(ram_we), 32'(e.we));
                        chk("spi_addr", 32'(ram_addr), 32'(e.a));
                        if (e.we) begin
                            chk("spi_wdata", 32'(ram_wdata), 32'(e.d));
                            ref_mem[e.a] = e.d;
                        end else tq.push_back('{c: cyc, d: ref_mem[e.a]});
                    end
                    spi_cyc = cyc;
                end
                if (tx_valid) begin
                    n_tx++;
                    if (tq.size() == 0) chk("tx_unexpected", 32'(tq.size()), 1);
                    else begin
                        r = tq.pop_front();
                        chk("tx_data", 32'(tx_data), 32'(r.d));
                        chk("tx_latency", 32'(cyc - r.c), 2);
                    end
                end
                if (host_rvalid) begin
                    if (hq.size() == 0) chk("rvalid_unexpected", 32'(hq.size()), 1);
                    else begin
                        r = hq.pop_front();
                        chk("host_rdata", 32'(host_rdata), 32'(r.d));
                        chk("host_latency", 32'(cyc - r.c), 2);
                    end
                end
            end
        end
    endtask

    initial begin
        int t;
        logic [9:0] w;
        fork monitor(); join_none
        #2 rst_n = 0;
        for (int i = 0; i < 256; i++) begin
            fill_a = 8'(i); fill_d = 8'($urandom); ref_mem[i] = fill_d; fill = 1;
            @(negedge clk);
        end
        fill = 0;
        chk("rst_flags", 32'({ram_en, ram_we, tx_valid, host_gnt, host_rvalid, spi_ovf}), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_host_rdata", 32'(host_rdata), 0);
        rst_n = 1;
        @(negedge clk);
        // write 0xA5 to 0x12
        t = n_tx;
        send(10'h012, 1, 0);
        repeat (3) @(negedge clk);
        send(10'h1A5, 1, 0);
        @(negedge clk);
        chk("wr_strobe", 32'({ram_en, ram_we}), 3);
        chk("wr_addr", 32'(ram_addr), 32'h12);
        chk("wr_wdata", 32'(ram_wdata), 32'hA5);
        @(negedge clk);
        chk("wr_strobe_1cyc", 32'(ram_en), 0);
        repeat (4) @(negedge clk);
        chk("wr_no_tx", 32'(n_tx - t), 0);
        // read back 0x12
        send(10'h212, 1, 0);
        @(negedge clk);
        send(10'h300, 1, 0);
        @(negedge clk);
        chk("rd_strobe", 32'({ram_en, ram_we}), 2);
        chk("rd_addr", 32'(ram_addr), 32'h12);
        @(negedge clk);
        chk("rd_tx_early", 32'(tx_valid), 0);
        @(negedge clk);
        chk("rd_tx_valid", 32'(tx_valid), 1);
        chk("rd_tx_data", 32'(tx_data), 32'hA5);
        @(negedge clk);
        chk("rd_tx_pulse", 32'(tx_valid), 0);
        chk("rd_tx_hold", 32'(tx_data), 32'hA5);
        // held level issues one command
        t = n_spi_wr;
        send(10'h1A5, 20, 0);
        repeat (5) @(negedge clk);
        chk("held_one_write", 32'(n_spi_wr - t), 1);
        // collision after reset: SPI wins, host follows
        do_reset();
        fork
            send(10'h177, 1, 0);
            begin @(negedge clk); host_do(0, 8'h40, 8'h00); end
        join
        repeat (4) @(negedge clk);
        chk("coll1_order", 32'(host_cyc - spi_cyc), 2);
        chk("coll1_rdata", 32'(host_rdata), 32'(ref_mem[8'h40]));
        send(10'h155, 1, 0);
        repeat (5) @(negedge clk);
        fork
            send(10'h166, 1, 0);
            begin @(negedge clk); host_do(1, 8'h41, 8'h99); end
        join
        repeat (4) @(negedge clk);
        chk("coll2_order", 32'(spi_cyc - host_cyc), 2);
        chk("coll2_ovf", 32'(spi_ovf), 0);
        // overflow: host holds the port while a second write arrives
        send(10'h020, 1, 0);
        repeat (2) @(negedge clk);
        fork
            begin send(10'h1C1, 1, 0); @(negedge clk); send(10'h1C2, 1, 1); end
            begin @(negedge clk); host_do(0, 8'h42, 8'h00); end
        join
        repeat (8) @(negedge clk);
        chk("ovf_set", 32'(spi_ovf), 1);
        chk("ovf_first_written", 32'(ref_mem[8'h20]), 32'hC1);
        repeat (10) @(negedge clk);
        chk("ovf_sticky", 32'(spi_ovf), 1);
        // reset during SPI_RD
        t = n_tx;
        send(10'h300, 1, 0);
        repeat (2) @(negedge clk);
        rst_n = 0; m_wr = 0; m_rd = 0;
        #1;
        chk("arst_flags", 32'({ram_en, ram_we, tx_valid, host_gnt, host_rvalid, spi_ovf}), 0);
        chk("arst_data", 32'({ram_addr, ram_wdata, tx_data, host_rdata}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (6) @(negedge clk);
        chk("arst_no_tx", 32'(n_tx - t), 0);
        // randomized traffic, spaced so no command is dropped
        for (int k = 0; k < 80; k++) begin
            w = {2'($urandom_range(0, 3)), 8'($urandom)};
            t = $urandom_range(1, 4);
            fork
                begin send(w, t, 0); repeat (8) @(negedge clk); end
                begin
                    if ($urandom_range(0, 1) == 1) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        host_do(1'($urandom), 8'($urandom), 8'($urandom));
                    end
                end
            join
        end
        repeat (10) @(negedge clk);
        chk("end_spi_q", 32'(sq.size()), 0);
        chk("end_tx_q", 32'(tq.size()), 0);
        chk("end_host_q", 32'(hq.size()), 0);
        chk("end_no_ovf", 32'(spi_ovf), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Sequences the single-port RAM behind the SPI slave.
- Decodes 10-bit SPI command words (rx_data[9:8] opcode, rx_data[7:0] payload) into RAM address latches, writes and reads, and returns read data to the slave via tx_valid/tx_data.
- Shares the one RAM port between the SPI command path and a local host port using round-robin arbitration.

Parameters:
- ADDR_WIDTH, 8, RAM address width; must equal payload width 8.
- DATA_WIDTH, 8, RAM data width; must equal payload and tx_data width 8.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  SPI word valid; level, may stay high many cycles
- rx_data  in  10  SPI word: [9:8] opcode, [7:0] payload
- tx_valid  out  1  read data valid to SPI slave, 1-cycle pulse
- tx_data  out  8  read data to SPI slave
- host_req  in  1  host access request, held until host_gnt
- host_we  in  1  host write(1)/read(0)
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  host write data
- host_gnt  out  1  1-cycle pulse, host access issued
- host_rvalid  out  1  1-cycle pulse, host_rdata valid
- host_rdata  out  DATA_WIDTH  host read data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read strobe is sampled
- spi_ovf  out  1  sticky: SPI command dropped

Behaviour:
- Reset (async, rst_n=0): all outputs 0; wr_addr=rd_addr=0; spi_pend=0; prio=SPI; state=IDLE; rx_valid edge detector cleared.
- Command acceptance: on the rising edge of rx_valid only (rx_valid=1 and registered previous value=0). A held level never re-issues a command.
- Opcode 00: wr_addr<=payload at acceptance edge; no RAM access.
- Opcode 10: rd_addr<=payload at acceptance edge; no RAM access.
- Opcode 01 (write): spi_pend<=1, op<=write, op_addr<=wr_addr, op_data<=payload.
- Opcode 11 (read): spi_pend<=1, op<=read, op_addr<=rd_addr; payload ignored.
- Address latch and a write/read accepted on consecutive commands: the data op uses the latched address current at its acceptance edge.
- Overflow: a write or read accepted while spi_pend=1 is discarded, spi_pend and op are unchanged, and spi_ovf<=1 until reset. Address-latch opcodes are never dropped.
- FSM states:
  - IDLE: if spi_pend and host_req are both set, the winner is prio. A sole requester wins. With no request, stay in IDLE.
  - SPI_ACC: ram_en=1, ram_we=op, ram_addr=op_addr, ram_wdata=op_data for exactly 1 cycle; spi_pend cleared; prio<=HOST. Next state is SPI_RD if read, else IDLE.
  - HOST_ACC: ram_en=1 with host_we/addr/wdata; host_gnt=1 in the same cycle; prio<=SPI. Next state is HOST_RD if read, else IDLE.
  - SPI_RD: 1 cycle; tx_data<=ram_rdata and tx_valid pulses the following cycle; then IDLE.
  - HOST_RD: same as SPI_RD, driving host_rdata/host_rvalid; then IDLE.
- Registered RAM outputs: ram_en/ram_we/ram_addr/ram_wdata are registered. ram_en=0 outside the ACC states; ram_addr/ram_wdata hold their last value.
- SPI latency: acceptance edge E. The RAM strobe is high in the cycle after edge E+1 when uncontended. The tx_valid pulse starts 2 cycles after the strobe cycle.
- tx_data holds its value until the next SPI read. host_rdata holds until the next host read.
- The next arbitration is possible in the cycle after IDLE is re-entered. There is at most one RAM access in flight.
- Host signals are sampled only in IDLE. host_req dropped before grant: no access.
- Reset mid-access: the access is aborted and no tx_valid/host_rvalid pulse is produced.

Test Plan:
- Words 0x012, 0x1A5 (one rx_valid rising edge each) -> ram_en=1, ram_we=1, addr 0x12, wdata 0xA5 for one cycle; no tx_valid.
- Words 0x212, 0x300, with RAM[0x12]=0xA5 -> one read strobe at addr 0x12; tx_valid 1-cycle pulse with tx_data=0xA5 two cycles after the strobe.
- rx_valid held high 20 cycles with word 0x1A5 -> exactly one RAM write.
- SPI write pending and host_req (read 0x40) in the same IDLE cycle after reset -> SPI write granted first, then host read. host_gnt asserts with the second strobe; host_rvalid returns RAM[0x40]. A repeat of the collision grants host first.
- Two write commands with the second accepted before the first is granted (host holding the port) -> first written, second dropped, spi_ovf=1 and remains 1.
- rst_n low during SPI_RD -> all outputs 0 immediately; no tx_valid after release; spi_ovf=0.
